// File: rtl/rot_word_pipe_if.sv
// Handshake and data bundle for rot_word_pipe: upstream word request plus downstream result.
// master = the side that feeds words and accepts results; slave = the rotator.
interface rot_word_pipe_if #(
  parameter int unsigned NUM_BYTES = 4
) ();
  localparam int unsigned AW = $clog2(NUM_BYTES);
  localparam int unsigned WW = 8 * NUM_BYTES;

  logic          i_valid;
  logic          o_ready;
  logic [WW-1:0] i_word;
  logic [AW-1:0] i_amount;
  logic          i_dir;
  logic          i_rcon_restart;
  logic          o_valid;
  logic          i_ready;
  logic [WW-1:0] o_word;
  logic [7:0]    o_rcon;
  logic [3:0]    o_round;

  modport master (
    output i_valid, i_word, i_amount, i_dir, i_rcon_restart, i_ready,
    input  o_ready, o_valid, o_word, o_rcon, o_round
  );

  modport slave (
    input  i_valid, i_word, i_amount, i_dir, i_rcon_restart, i_ready,
    output o_ready, o_valid, o_word, o_rcon, o_round
  );
endinterface

// File: rtl/rot_word_pipe.sv
// Two-stage byte rotator for key expansion with an internal Rcon/round generator.
// S1 holds the rotated word and its Rcon tag; S2 applies the Rcon XOR to byte 0.
module rot_word_pipe #(
  parameter int unsigned NUM_BYTES  = 4,
  parameter bit          RCON_EN    = 1'b1,
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rot_word_pipe_if.slave bus
);
  localparam int unsigned WW = 8 * NUM_BYTES;

  logic          s1_valid_q, s1_valid_d;
  logic [WW-1:0] s1_word_q, s1_word_d;
  logic [7:0]    s1_rcon_q, s1_rcon_d;
  logic [3:0]    s1_round_q, s1_round_d;
  logic          out_valid_q, out_valid_d;
  logic [WW-1:0] out_word_q, out_word_d;
  logic [7:0]    out_rcon_q, out_rcon_d;
  logic [3:0]    out_round_q, out_round_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [3:0]    round_q, round_d;

  logic            s2_load_c, s1_load_c, ready_c, accept_c;
  logic [2*WW-1:0] dbl_c;
  int unsigned     shift_c;
  logic [WW-1:0]   rot_word_c;
  logic [7:0]      cur_rcon_c;
  logic [3:0]      cur_round_c;

  assign s2_load_c = !out_valid_q || bus.i_ready;
  assign s1_load_c = !s1_valid_q || s2_load_c;
  assign ready_c   = i_rst_n && s1_load_c;
  assign accept_c  = bus.i_valid && ready_c;

  // Rotate by sliding a window over two back-to-back copies of the word.
  always_comb begin
    dbl_c   = {bus.i_word, bus.i_word};
    shift_c = 8 * (32'(bus.i_amount) % NUM_BYTES);
    if (bus.i_dir) rot_word_c = WW'(dbl_c >> shift_c);
    else           rot_word_c = WW'((dbl_c << shift_c) >> WW);
  end

  // Rcon generator: restart overrides the value seen by the accepted word.
  always_comb begin
    cur_rcon_c  = 8'h00;
    cur_round_c = 4'd0;
    rcon_d      = rcon_q;
    round_d     = round_q;
    if (RCON_EN) begin
      cur_rcon_c  = bus.i_rcon_restart ? 8'h01 : rcon_q;
      cur_round_c = bus.i_rcon_restart ? 4'd1 : round_q;
      if (accept_c) begin
        if (cur_round_c == 4'(NUM_ROUNDS)) begin
          rcon_d  = 8'h01;
          round_d = 4'd1;
        end else begin
          rcon_d  = {cur_rcon_c[6:0], 1'b0} ^ (cur_rcon_c[7] ? 8'h1B : 8'h00);
          round_d = cur_round_c + 4'd1;
        end
      end else if (bus.i_rcon_restart) begin
        rcon_d  = 8'h01;
        round_d = 4'd1;
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_word_d   = s1_word_q;
    s1_rcon_d   = s1_rcon_q;
    s1_round_d  = s1_round_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_rcon_d  = out_rcon_q;
    out_round_d = out_round_q;
    if (s1_load_c) begin
      s1_valid_d = accept_c;
      if (accept_c) begin
        s1_word_d  = rot_word_c;
        s1_rcon_d  = cur_rcon_c;
        s1_round_d = cur_round_c;
      end
    end
    // Payload only changes when a new word moves in, so stalled outputs stay bit-stable.
    if (s2_load_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_word_d  = s1_word_q ^ {s1_rcon_q, {(WW-8){1'b0}}};
        out_rcon_d  = s1_rcon_q;
        out_round_d = s1_round_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      s1_rcon_q   <= 8'h00;
      s1_round_q  <= 4'd0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_rcon_q  <= 8'h00;
      out_round_q <= 4'd0;
      rcon_q      <= 8'h01;
      round_q     <= 4'd1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_word_q   <= s1_word_d;
      s1_rcon_q   <= s1_rcon_d;
      s1_round_q  <= s1_round_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_rcon_q  <= out_rcon_d;
      out_round_q <= out_round_d;
      rcon_q      <= rcon_d;
      round_q     <= round_d;
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_valid = out_valid_q;
  assign bus.o_word  = out_word_q;
  assign bus.o_rcon  = out_rcon_q;
  assign bus.o_round = out_round_q;
endmodule
